// File: rtl/myproject_mac_pkg.sv
// Shared types and helpers for the myproject MAC accumulator slice.
//   mac_state_t : 2-bit FSM encoding (IDLE/ACCUM/FINAL/OUT)
//   out_max/min : saturation bounds for a signed output of a given width
//   sext        : sign-extend the low w bits of a 64-bit container
package myproject_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FINAL = 2'd2,
        ST_OUT   = 2'd3
    } mac_state_t;

    function automatic logic signed [63:0] out_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] out_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Masks to w bits, then (x ^ signbit) - signbit replicates the sign bit upward.
    function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
        logic [63:0] m;
        logic [63:0] sb;
        m  = (64'd1 << w) - 64'd1;
        sb = 64'd1 << (w - 1);
        return ((v & m) ^ sb) - sb;
    endfunction

endpackage

// File: rtl/myproject_mac_shift_sat.sv
// Combinational rescale: arithmetic right shift of the accumulator by
// FRAC_SHIFT, then clamp to the signed OUT_WIDTH range.
// Optional macro MYPROJECT_MAC_RELU_EN: negative results are forced to 0.
// Ports:
//   acc_in  : ACC_WIDTH signed accumulator value
//   sat_out : OUT_WIDTH signed shifted/saturated result
module myproject_mac_shift_sat
    import myproject_mac_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = 28,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned FRAC_SHIFT = 4
) (
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    output logic signed [OUT_WIDTH-1:0] sat_out
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(out_max(OUT_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(out_min(OUT_WIDTH));

    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic signed [OUT_WIDTH-1:0] w_sat;

    assign w_shifted = acc_in >>> FRAC_SHIFT;

    always_comb begin
        w_sat = w_shifted[OUT_WIDTH-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

`ifdef MYPROJECT_MAC_RELU_EN
    assign sat_out = w_sat[OUT_WIDTH-1] ? '0 : w_sat;
`else
    assign sat_out = w_sat;
`endif

endmodule

// File: rtl/myproject_mac_accum_20s.sv
// Product accumulator: sums N_TERMS signed products plus a per-group bias,
// rescales by FRAC_SHIFT and saturates to OUT_WIDTH.
// Optional macro MYPROJECT_MAC_RELU_EN (see myproject_mac_shift_sat).
// Ports:
//   ap_clk, ap_rst_n          : clock, async active-low reset
//   prod_din/valid/ready      : product input stream
//   bias_din                  : bias, sampled on the first product of a group
//   out_dout/valid/ready      : result output stream
//   busy                      : high whenever the FSM is not IDLE
module myproject_mac_accum_20s
    import myproject_mac_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = 20,
    parameter int unsigned ACC_WIDTH  = 28,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned N_TERMS    = 9,
    parameter int unsigned FRAC_SHIFT = 4
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [PROD_WIDTH-1:0] prod_din,
    input  logic                         prod_valid,
    output logic                         prod_ready,
    input  logic signed [ACC_WIDTH-1:0]  bias_din,
    output logic signed [OUT_WIDTH-1:0]  out_dout,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    mac_state_t                  r_state;
    mac_state_t                  w_state_nxt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]            r_cnt;
    logic signed [OUT_WIDTH-1:0] r_out_dout;
    logic                        r_out_valid;

    logic                        w_prod_ready;
    logic                        w_prod_hs;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_bias_ext;
    logic signed [OUT_WIDTH-1:0] w_sat;

    assign w_prod_ext = ACC_WIDTH'(sext(64'(prod_din), PROD_WIDTH));
    assign w_bias_ext = ACC_WIDTH'(sext(64'(bias_din), ACC_WIDTH));
    assign w_prod_hs  = prod_valid && w_prod_ready;

    myproject_mac_shift_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .FRAC_SHIFT(FRAC_SHIFT)
    ) u_shift_sat (
        .acc_in (r_acc),
        .sat_out(w_sat)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_prod_ready = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_prod_ready = 1'b1;
                if (w_prod_hs) begin
                    w_state_nxt = (N_TERMS == 1) ? ST_FINAL : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                w_prod_ready = 1'b1;
                if (w_prod_hs && (r_cnt == CNT_LAST)) begin
                    w_state_nxt = ST_FINAL;
                end
            end
            ST_FINAL: begin
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                // out_valid is always high in OUT, so out_ready alone completes it
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_dout  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_prod_hs) begin
                        r_acc <= w_bias_ext + w_prod_ext;
                        r_cnt <= CNT_W'(1);
                    end
                end
                ST_ACCUM: begin
                    if (w_prod_hs) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_FINAL: begin
                    r_out_dout  <= w_sat;
                    r_out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign prod_ready = w_prod_ready;
    assign out_dout   = r_out_dout;
    assign out_valid  = r_out_valid;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_myproject_mac_accum_20s.sv
module tb_myproject_mac_accum_20s;

`ifdef MYPROJECT_MAC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic               ap_clk;
    logic               ap_rst_n;
    logic signed [19:0] prod_din;
    logic               prod_valid;
    logic               prod_ready;
    logic signed [27:0] bias_din;
    logic signed [15:0] out_dout;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    int unsigned n_pass;
    int unsigned n_total;

    myproject_mac_accum_20s #(
        .PROD_WIDTH(20),
        .ACC_WIDTH (28),
        .OUT_WIDTH (16),
        .N_TERMS   (9),
        .FRAC_SHIFT(4)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .prod_din  (prod_din),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .bias_din  (bias_din),
        .out_dout  (out_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Drives nterms copies of p starting at a negedge; a set bit i in gaps
    // inserts one idle cycle (with junk data) before term i. Bias is only
    // meaningful on term 0; later terms present random bias values.
    task automatic drive_group(input logic signed [19:0] p, input logic signed [27:0] bias,
                               input int unsigned nterms, input logic [31:0] gaps);
        for (int unsigned i = 0; i < nterms; i++) begin
            if (gaps[i]) begin
                prod_valid = 1'b0;
                prod_din   = 20'($urandom());
                bias_din   = 28'($urandom());
                @(negedge ap_clk);
            end
            prod_valid = 1'b1;
            prod_din   = p;
            bias_din   = (i == 0) ? bias : 28'($urandom());
            @(negedge ap_clk);
        end
        prod_valid = 1'b0;
        prod_din   = '0;
    endtask

    task automatic test_reset();
        ap_rst_n   = 1'b0;
        prod_valid = 1'b0;
        prod_din   = '0;
        bias_din   = '0;
        out_ready  = 1'b1;
        repeat (2) @(negedge ap_clk);
        n_total++; if (out_dout !== 16'sd0) $display("FAIL reset_dout got %0d exp 0", out_dout); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_total++; if (prod_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", prod_ready); else n_pass++;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive_group(20'sd16, 28'sd0, 9, 32'd0);
        // one edge after the last accept: in FINAL, result not yet visible
        n_total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_e1 got %b exp 0", out_valid); else n_pass++;
        n_total++; if (prod_ready !== 1'b0) $display("FAIL basic_ready_final got %b exp 0", prod_ready); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", busy); else n_pass++;
        @(negedge ap_clk);
        n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid_e2 got %b exp 1", out_valid); else n_pass++;
        n_total++; if (out_dout !== 16'sd9) $display("FAIL basic_dout got %0d exp 9", out_dout); else n_pass++;
        @(negedge ap_clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_e3 got %b exp 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL basic_idle got %b exp 0", busy); else n_pass++;
        n_total++; if (prod_ready !== 1'b1) $display("FAIL basic_ready_idle got %b exp 1", prod_ready); else n_pass++;
    endtask

    task automatic test_arith();
        logic signed [19:0] tp [10];
        logic signed [27:0] tb [10];
        logic signed [15:0] te [10];
        logic signed [15:0] exp_v;
        int unsigned k;
        // product, bias, signed saturated expectation (before optional ReLU)
        tp[0] = 20'sd16;      tb[0] = 28'sd32;       te[0] = 16'sd11;     // 176>>>4
        tp[1] = -20'sd16;     tb[1] = 28'sd0;        te[1] = -16'sd9;     // -144>>>4
        tp[2] = -20'sd15;     tb[2] = 28'sd0;        te[2] = -16'sd9;     // -135>>>4 floors
        tp[3] = 20'sd524287;  tb[3] = 28'sd0;        te[3] = 16'sd32767;  // 4718583>>>4=294911
        tp[4] = -20'sd524288; tb[4] = 28'sd0;        te[4] = -16'sd32768; // -294912
        tp[5] = 20'sd0;       tb[5] = 28'sd524287;   te[5] = 16'sd32767;  // exactly max
        tp[6] = 20'sd0;       tb[6] = 28'sd524288;   te[6] = 16'sd32767;  // max+1 clamps
        tp[7] = 20'sd0;       tb[7] = -28'sd524288;  te[7] = -16'sd32768; // exactly min
        tp[8] = 20'sd0;       tb[8] = -28'sd524289;  te[8] = -16'sd32768; // min-1 clamps
        tp[9] = 20'sd100;     tb[9] = -28'sd1000;    te[9] = -16'sd6;     // -100>>>4 = -7? no: 900-1000=-100 -> -7
        te[9] = -16'sd7;
        out_ready = 1'b1;
        for (int unsigned t = 0; t < 10; t++) begin
            drive_group(tp[t], tb[t], 9, 32'd0);
            k = 0;
            while (out_valid !== 1'b1 && k < 8) begin
                @(negedge ap_clk);
                k++;
            end
            exp_v = (RELU && te[t] < 0) ? 16'sd0 : te[t];
            n_total++;
            if (k >= 8) $display("FAIL arith%0d_timeout got no out_valid exp out_valid=1", t);
            else if (out_dout !== exp_v) $display("FAIL arith%0d_dout got %0d exp %0d", t, out_dout, exp_v);
            else n_pass++;
            @(negedge ap_clk);
        end
    endtask

    task automatic test_bubbles();
        out_ready = 1'b1;
        drive_group(20'sd16, 28'sd0, 9, 32'b1_0110_1101);
        // counter advanced only on the 9 handshakes, so FINAL follows the 9th
        n_total++; if (prod_ready !== 1'b0) $display("FAIL bubbles_final got ready=%b exp 0", prod_ready); else n_pass++;
        @(negedge ap_clk);
        n_total++; if (out_valid !== 1'b1 || out_dout !== 16'sd9)
            $display("FAIL bubbles_dout got %0d/v%b exp 9/v1", out_dout, out_valid); else n_pass++;
        @(negedge ap_clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_group(20'sd16, 28'sd0, 9, 32'd0);
        @(negedge ap_clk);
        for (int unsigned c = 0; c < 5; c++) begin
            prod_valid = c[0];
            prod_din   = 20'sd1000;
            @(negedge ap_clk);
            n_total++;
            if (out_valid !== 1'b1 || out_dout !== 16'sd9 || prod_ready !== 1'b0)
                $display("FAIL bp_hold%0d got v%b d%0d r%b exp v1 d9 r0", c, out_valid, out_dout, prod_ready);
            else n_pass++;
        end
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        @(negedge ap_clk);
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL bp_release got v%b busy%b exp v0 busy0", out_valid, busy); else n_pass++;
        drive_group(20'sd16, 28'sd0, 9, 32'd0);
        @(negedge ap_clk);
        n_total++; if (out_valid !== 1'b1 || out_dout !== 16'sd9)
            $display("FAIL bp_next got %0d/v%b exp 9/v1", out_dout, out_valid); else n_pass++;
        @(negedge ap_clk);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive_group(20'sd2000, 28'sd5000, 4, 32'd0);
        ap_rst_n = 1'b0;
        #1;
        n_total++; if (out_dout !== 16'sd0 || out_valid !== 1'b0 || busy !== 1'b0 || prod_ready !== 1'b1)
            $display("FAIL rstmid_outputs got d%0d v%b b%b r%b exp d0 v0 b0 r1", out_dout, out_valid, busy, prod_ready);
        else n_pass++;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0 || prod_ready !== 1'b1)
            $display("FAIL rstmid_release got v%b b%b r%b exp v0 b0 r1", out_valid, busy, prod_ready); else n_pass++;
        drive_group(20'sd16, 28'sd0, 9, 32'd0);
        @(negedge ap_clk);
        n_total++; if (out_valid !== 1'b1 || out_dout !== 16'sd9)
            $display("FAIL rstmid_next got %0d/v%b exp 9/v1", out_dout, out_valid); else n_pass++;
        @(negedge ap_clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_arith();
        test_bubbles();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

endmodule
